// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: 16-bit up/down counter with a multiplexed four-digit
// hex display scanner, including optional leading-zero blanking.
module display_scan_ctrl #(
    parameter int SCAN_DIV = 50000,
    parameter int STEP_DIV = 50000000,
    parameter int LZB      = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        up,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic [15:0] count_val,
    output logic [3:0]  seg_code,
    output logic [3:0]  digit_sel
);

    localparam int SCAN_W = $clog2(SCAN_DIV);
    localparam int STEP_W = $clog2(STEP_DIV);
    localparam logic [SCAN_W-1:0] SCAN_MAX = SCAN_W'(SCAN_DIV - 1);
    localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(STEP_DIV - 1);

    logic [SCAN_W-1:0] scan_cnt;
    logic [STEP_W-1:0] step_cnt;
    logic [1:0]        idx;
    logic              scan_tick;
    logic              step_tick;
    logic [3:0]        nib;
    logic              upper_zero;
    logic              blank;
    logic [3:0]        next_seg;
    logic [3:0]        next_sel;

    assign scan_tick = (scan_cnt == SCAN_MAX);
    assign step_tick = en && (step_cnt == STEP_MAX);

    // Free-running scan prescaler; the digit index moves on each wrap and never reacts to load or en.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt <= '0;
            idx      <= 2'd0;
        end else if (scan_tick) begin
            scan_cnt <= '0;
            idx      <= idx + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // Step prescaler and counter; a load wins over a coincident step, which is dropped rather than deferred.
    always_ff @(posedge clk) begin
        if (rst) begin
            step_cnt  <= '0;
            count_val <= 16'h0000;
        end else if (load) begin
            step_cnt  <= '0;
            count_val <= load_val;
        end else if (en) begin
            if (step_tick) begin
                step_cnt  <= '0;
                count_val <= up ? (count_val + 16'd1) : (count_val - 16'd1);
            end else begin
                step_cnt <= step_cnt + 1'b1;
            end
        end
    end

    // Select the active nibble and decide whether it is a leading zero to be blanked.
    always_comb begin
        nib        = count_val[3:0];
        upper_zero = 1'b0;
        case (idx)
            2'd0: begin
                nib        = count_val[3:0];
                upper_zero = 1'b0;
            end
            2'd1: begin
                nib        = count_val[7:4];
                upper_zero = (count_val[15:4] == 12'h000);
            end
            2'd2: begin
                nib        = count_val[11:8];
                upper_zero = (count_val[15:8] == 8'h00);
            end
            default: begin
                nib        = count_val[15:12];
                upper_zero = (count_val[15:12] == 4'h0);
            end
        endcase
        blank    = (LZB != 0) && upper_zero;
        next_seg = blank ? 4'h0 : nib;
        next_sel = blank ? 4'b1111 : ~(4'b0001 << idx);
    end

    // Register the display outputs so they follow idx and count_val by one cycle, glitch-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_code  <= 4'h0;
            digit_sel <= 4'b1110;
        end else begin
            seg_code  <= next_seg;
            digit_sel <= next_sel;
        end
    end

endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 50000: clock cycles per digit scan slot (range 2..2^20).
REQ-002 The block SHALL have parameter STEP_DIV, default 50000000: clock cycles per counter step (range 2..2^27).
REQ-003 The block SHALL have parameter LZB, default 1: when 1, leading-zero blanking is enabled.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port en, input, 1 bit: counter step enable.
REQ-007 The block SHALL have port up, input, 1 bit: count direction; 1 = increment, 0 = decrement.
REQ-008 The block SHALL have port load, input, 1 bit: single-cycle request to load load_val into the counter.
REQ-009 The block SHALL have port load_val, input, 16 bits: counter load value, four hex nibbles.
REQ-010 The block SHALL have port count_val, output, 16 bits: current counter value.
REQ-011 The block SHALL have port seg_code, output, 4 bits: nibble for the active digit, feeding the downstream 7-segment decoder.
REQ-012 The block SHALL have port digit_sel, output, 4 bits: active-low one-hot digit enable; bit i drives digit i, with digit 0 least significant.

Function
REQ-013 A scan prescaler SHALL count 0..SCAN_DIV-1 and wrap; scan_tick is asserted on the cycle the prescaler equals SCAN_DIV-1.
REQ-014 The 2-bit digit index idx SHALL advance on each scan_tick, 0->1->2->3->0, and is otherwise held.
REQ-015 A step prescaler SHALL count 0..STEP_DIV-1 and wrap; step_tick is asserted at STEP_DIV-1; it runs only while en=1 and holds its value while en=0.
REQ-016 On step_tick, count_val SHALL change by +1 if up=1 or -1 if up=0, modulo 2^16: 0xFFFF+1 -> 0x0000 and 0x0000-1 -> 0xFFFF.
REQ-017 load=1 SHALL set count_val<=load_val on that edge, independent of en, and clear the step prescaler to 0.
REQ-018 If load and step_tick coincide, the load SHALL take priority and the step is discarded, not deferred.
REQ-019 seg_code and digit_sel SHALL be registered, computed each cycle from the current idx and count_val, giving 1-cycle latency from any idx or count_val change.
REQ-020 seg_code SHALL equal count_val[4*idx+3 : 4*idx].
REQ-021 digit_sel SHALL equal ~(4'b0001 << idx) unless the digit is blanked.
REQ-022 When LZB=1, digit i (i>=1) SHALL be blanked, with digit_sel=4'b1111 and seg_code=0, if count_val nibbles i..3 are all zero; digit 0 SHALL never be blanked.
REQ-023 When LZB=0, no digit SHALL be blanked.
REQ-024 The scan SHALL run continuously regardless of en or load; load SHALL NOT disturb idx or the scan prescaler.
REQ-025 At most one bit of digit_sel SHALL be low in any cycle.

Reset
REQ-026 While rst=1 at a clock edge, all state SHALL be cleared: count_val=0x0000, idx=0, both prescalers=0, seg_code=4'h0, digit_sel=4'b1110.
REQ-027 rst SHALL take priority over load and any tick; assertion mid-scan or mid-step SHALL discard the pending step.
REQ-028 Operation SHALL resume from the reset state on the first edge after rst deasserts.

Verification (SCAN_DIV=4, STEP_DIV=8, LZB=1 unless noted)
REQ-029 Scan order: rst, then load 0x1234, en=0 -> digit_sel cycles 1110/1101/1011/0111, 4 clocks each, with seg_code 4/3/2/1, and repeats.
REQ-030 Wrap, both directions: load 0xFFFE, en=1, up=1 -> 0xFFFF after 8 clocks, 0x0000 after 16; then up=0 -> 0xFFFF after 8 more clocks.
REQ-031 Load/step collision: load 0x00A0 pulsed on the step_tick cycle -> count_val=0x00A0, no step applied, next step 8 clocks later gives 0x00A1.
REQ-032 Blanking: count_val=0x0005 -> digits 1-3 give digit_sel=1111, digit 0 gives 1110 with seg_code=5. With LZB=0, all four digits are enabled, showing 0,0,0,5.
REQ-033 Reset mid-operation: rst asserted at step prescaler=6, idx=2, count_val=0x0042 -> next edge count_val=0, digit_sel=1110, seg_code=0; no step occurs at the old tick time.
REQ-034 en gating: en=0 for 20 clocks mid-count -> count_val held and step prescaler frozen; the step occurs after the remaining prescaler cycles once en=1.
